// File: rtl/learn_ctrl.sv
// learn_ctrl: learn-mode sequencer for the piano.
// Walks a song ROM by note index, highlights the note the player must press,
// waits for that key to be held for the note's full length, counts wrong or
// early-released presses, and reports when the song is finished.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   start             - one-cycle pulse, begins the song from index 0
//   abort             - level, returns to IDLE (err_cnt is kept)
//   key[4:0]          - decoded pressed note, 0 = no key
//   rom_music[4:0]    - note at cnt (combinational ROM), 0 = end of song
//   rom_interval[2:0] - note length in beats, 0 is treated as 1
//   cnt[5:0]          - ROM index
//   expect_note[4:0]  - note to highlight, 0 when not active
//   note_ok           - one-cycle pulse when a note is completed
//   wrong             - one-cycle pulse on a wrong press or early release
//   err_cnt[7:0]      - saturating count of wrong presses
//   busy              - high in every state except IDLE and DONE
//   done              - high in DONE until the next start or rst
module learn_ctrl #(
  parameter int BEAT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] key,
  input  logic [4:0] rom_music,
  input  logic [2:0] rom_interval,
  output logic [5:0] cnt,
  output logic [4:0] expect_note,
  output logic       note_ok,
  output logic       wrong,
  output logic [7:0] err_cnt,
  output logic       busy,
  output logic       done
);

  // A one-cycle beat still needs a 1-bit counter to keep the logic legal.
  localparam int            BW        = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_KEY,
    HOLD,
    RELEASE,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [4:0]    key_prev;
  logic [BW-1:0] beat, beat_nx;
  logic [2:0]    beats_left, beats_left_nx;
  logic [2:0]    interval, interval_nx;
  logic [5:0]    cnt_nx;
  logic [4:0]    expect_nx;
  logic          note_ok_nx, wrong_nx, busy_nx, done_nx;
  logic [7:0]    err_nx, err_inc;
  logic [2:0]    rom_len;
  logic          press;

  // A press is a 0 -> nonzero transition, so a key still held from the
  // previous note never counts as a fresh press.
  assign press   = (key_prev == 5'd0) && (key != 5'd0);
  assign err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  assign rom_len = (rom_interval == 3'd0) ? 3'd1 : rom_interval;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    expect_nx     = expect_note;
    err_nx        = err_cnt;
    beat_nx       = beat;
    beats_left_nx = beats_left;
    interval_nx   = interval;
    note_ok_nx    = 1'b0;
    wrong_nx      = 1'b0;

    if (abort) begin
      state_nx  = IDLE;
      cnt_nx    = 6'd0;
      expect_nx = 5'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt_nx   = 6'd0;
            err_nx   = 8'd0;
            state_nx = FETCH;
          end
        end

        FETCH: begin
          if (rom_music == 5'd0) begin
            expect_nx = 5'd0;
            state_nx  = DONE;
          end else begin
            expect_nx     = rom_music;
            interval_nx   = rom_len;
            beats_left_nx = rom_len;
            state_nx      = WAIT_KEY;
          end
        end

        WAIT_KEY: begin
          if (press) begin
            if (key == expect_note) begin
              beat_nx  = '0;
              state_nx = HOLD;
            end else begin
              wrong_nx = 1'b1;
              err_nx   = err_inc;
            end
          end
        end

        HOLD: begin
          // Completion is checked before the key so a release on the very
          // cycle the last beat expires still counts as a finished note.
          if (beats_left == 3'd0) begin
            note_ok_nx = 1'b1;
            state_nx   = RELEASE;
          end else if (key != expect_note) begin
            wrong_nx      = 1'b1;
            err_nx        = err_inc;
            beats_left_nx = interval;
            state_nx      = WAIT_KEY;
          end else if (beat == BEAT_LAST) begin
            beat_nx       = '0;
            beats_left_nx = beats_left - 3'd1;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end

        RELEASE: begin
          if (key == 5'd0) begin
            if (cnt == 6'd63) begin
              expect_nx = 5'd0;
              state_nx  = DONE;
            end else begin
              cnt_nx   = cnt + 6'd1;
              state_nx = FETCH;
            end
          end
        end

        default: state_nx = IDLE;
      endcase
    end

    busy_nx = (state_nx != IDLE) && (state_nx != DONE);
    done_nx = (state_nx == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_prev    <= 5'd0;
      beat        <= '0;
      beats_left  <= 3'd0;
      interval    <= 3'd0;
      cnt         <= 6'd0;
      expect_note <= 5'd0;
      note_ok     <= 1'b0;
      wrong       <= 1'b0;
      err_cnt     <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      key_prev    <= key;
      beat        <= beat_nx;
      beats_left  <= beats_left_nx;
      interval    <= interval_nx;
      cnt         <= cnt_nx;
      expect_note <= expect_nx;
      note_ok     <= note_ok_nx;
      wrong       <= wrong_nx;
      err_cnt     <= err_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_learn_ctrl.sv
// tb_learn_ctrl: directed self-checking bench for learn_ctrl with
// BEAT_CYCLES=4 and a bench-side song ROM indexed by the DUT's cnt.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_learn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] key = 5'd0;
  logic [4:0] rom_music;
  logic [2:0] rom_interval;
  logic [5:0] cnt;
  logic [4:0] expect_note;
  logic       note_ok;
  logic       wrong;
  logic [7:0] err_cnt;
  logic       busy;
  logic       done;

  logic [4:0] rom_m [64];
  logic [2:0] rom_i [64];

  int n_checks = 0;
  int n_errors = 0;

  assign rom_music    = rom_m[cnt];
  assign rom_interval = rom_i[cnt];

  always #5 clk = ~clk;

  learn_ctrl #(.BEAT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .key          (key),
    .rom_music    (rom_music),
    .rom_interval (rom_interval),
    .cnt          (cnt),
    .expect_note  (expect_note),
    .note_ok      (note_ok),
    .wrong        (wrong),
    .err_cnt      (err_cnt),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear;
    for (int i = 0; i < 64; i++) begin
      rom_m[i] = 5'd0;
      rom_i[i] = 3'd0;
    end
  endtask

  // start pulse, then FETCH: expect_note is valid after these two edges.
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
  endtask

  // Press n and hold it; latency is the number of edges after the edge that
  // sampled the press until note_ok is seen. The key stays held afterwards.
  task automatic play_note(input string tag, input logic [4:0] n, input int lat);
    int got;
    got = -1;
    key = n;
    tick;
    for (int k = 1; k < 40; k++) begin
      tick;
      if (note_ok) begin
        got = k;
        break;
      end
    end
    check(tag, got, lat);
  endtask

  // Release, RELEASE -> FETCH, FETCH -> WAIT_KEY.
  task automatic release_key;
    key = 5'd0;
    tick;
    tick;
  endtask

  initial begin
    int ok;
    rom_clear();

    // ---------------- reset state
    tick;
    tick;
    rst = 1'b0;
    check("rst_cnt", cnt, 0);
    check("rst_expect", expect_note, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cnt, 0);

    // ---------------- happy path: {13/1, 14/2, 0}
    rom_m[0] = 5'd13; rom_i[0] = 3'd1;
    rom_m[1] = 5'd14; rom_i[1] = 3'd2;
    do_start();
    check("hp_expect0", expect_note, 13);
    check("hp_busy", busy, 1);
    play_note("hp_lat1", 5'd13, 5);
    release_key();
    check("hp_expect1", expect_note, 14);
    check("hp_cnt1", cnt, 1);
    play_note("hp_lat2", 5'd14, 9);
    release_key();
    check("hp_done", done, 1);
    check("hp_busy_end", busy, 0);
    check("hp_cnt_end", cnt, 2);
    check("hp_err", err_cnt, 0);
    check("hp_expect_end", expect_note, 0);

    // ---------------- wrong key (restart from DONE): {13/1, 0}
    rom_clear();
    rom_m[0] = 5'd13; rom_i[0] = 3'd1;
    do_start();
    check("wk_done_clr", done, 0);
    check("wk_expect", expect_note, 13);
    key = 5'd12;
    tick;
    check("wk_wrong", wrong, 1);
    check("wk_err", err_cnt, 1);
    key = 5'd0;
    tick;
    check("wk_wrong_pulse", wrong, 0);
    play_note("wk_lat", 5'd13, 5);
    check("wk_err_after", err_cnt, 1);
    release_key();
    check("wk_done", done, 1);

    // ---------------- early release: {8/3, 0}
    rom_clear();
    rom_m[0] = 5'd8; rom_i[0] = 3'd3;
    do_start();
    check("er_err_clr", err_cnt, 0);
    key = 5'd8;
    for (int i = 0; i < 6; i++) tick;
    key = 5'd0;
    tick;
    check("er_wrong", wrong, 1);
    check("er_note_ok", note_ok, 0);
    check("er_err", err_cnt, 1);
    check("er_expect", expect_note, 8);
    check("er_busy", busy, 1);
    tick;
    play_note("er_full_lat", 5'd8, 13);
    check("er_err_after", err_cnt, 1);
    release_key();

    // ---------------- repeated note with key held: {11/1, 11/1, 0}
    rom_clear();
    rom_m[0] = 5'd11; rom_i[0] = 3'd1;
    rom_m[1] = 5'd11; rom_i[1] = 3'd1;
    do_start();
    play_note("rn_lat0", 5'd11, 5);
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (note_ok || cnt != 6'd0 || !busy) ok = 0;
    end
    check("rn_held_stays", ok, 1);
    release_key();
    check("rn_cnt1", cnt, 1);
    check("rn_expect1", expect_note, 11);
    play_note("rn_lat1", 5'd11, 5);
    release_key();
    check("rn_done", done, 1);

    // ---------------- saturation: {5/1, 0}, 300 wrong presses
    rom_clear();
    rom_m[0] = 5'd5; rom_i[0] = 3'd1;
    do_start();
    for (int i = 0; i < 300; i++) begin
      key = 5'd6;
      tick;
      key = 5'd0;
      tick;
      if (i == 253) check("sat_254", err_cnt, 254);
    end
    check("sat_255", err_cnt, 255);

    // ---------------- abort together with start
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_cnt", cnt, 0);
    check("ab_expect", expect_note, 0);
    check("ab_err_held", err_cnt, 255);
    tick;
    check("ab_stays_idle", busy, 0);

    // ---------------- full 64-entry song, no terminator, interval 0 -> 1
    for (int i = 0; i < 64; i++) begin
      rom_m[i] = 5'((i % 21) + 1);
      rom_i[i] = 3'd0;
    end
    do_start();
    check("fs_err_clr", err_cnt, 0);
    ok = 1;
    for (int i = 0; i < 64; i++) begin
      if (expect_note != 5'((i % 21) + 1) || cnt != 6'(i)) ok = 0;
      play_note("fs_lat", 5'((i % 21) + 1), 5);
      key = 5'd0;
      tick;
      if (i < 63) tick;
    end
    check("fs_sequence", ok, 1);
    check("fs_done", done, 1);
    check("fs_cnt", cnt, 63);
    check("fs_expect", expect_note, 0);

    // ---------------- reset mid-HOLD on note 3: {1/2, 2/2, 3/2, 4/2, 0}
    rom_clear();
    for (int i = 0; i < 4; i++) begin
      rom_m[i] = 5'(i + 1);
      rom_i[i] = 3'd2;
    end
    do_start();
    key = 5'd20;
    tick;
    key = 5'd0;
    tick;
    check("mr_err_pre", err_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      play_note("mr_lat", 5'(i + 1), 9);
      release_key();
    end
    check("mr_cnt_pre", cnt, 3);
    key = 5'd4;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    key = 5'd0;
    check("mr_cnt", cnt, 0);
    check("mr_err", err_cnt, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_expect", expect_note, 0);
    check("mr_pulses", {note_ok, wrong}, 0);
    tick;
    check("mr_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
